// File: rtl/swap_pkg.sv
// Shared definitions for the swap block: permutation mode encodings.
package swap_pkg;

  localparam logic [1:0] MODE_NIBBLE = 2'b00;
  localparam logic [1:0] MODE_BITREV = 2'b01;
  localparam logic [1:0] MODE_PASS   = 2'b10;
  localparam logic [1:0] MODE_PAIR   = 2'b11;

endpackage : swap_pkg

// File: rtl/swap_core.sv
// Combinational bit permutation. Pure wiring: no arithmetic and no carries.
// Every mode is self-inverse.
module swap_core
  import swap_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out
);

  // Select one of four fixed bit permutations
  always_comb begin
    out = in;
    case (mode)
      MODE_NIBBLE: out = {in[WIDTH/2-1:0], in[WIDTH-1:WIDTH/2]};
      MODE_BITREV: begin
        for (int i = 0; i < WIDTH; i++) begin
          out[i] = in[WIDTH-1-i];
        end
      end
      MODE_PASS:   out = in;
      MODE_PAIR: begin
        for (int k = 0; k < WIDTH/2; k++) begin
          out[2*k]   = in[2*k+1];
          out[2*k+1] = in[2*k];
        end
      end
      default:     out = in;
    endcase
  end

endmodule : swap_core

// File: rtl/swap.sv
// Swap top level: registers the permuted operand with one cycle of latency.
// Holds the last result while in_valid is low; out_valid flags fresh data.
module swap #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  logic [WIDTH-1:0] perm_p0;
  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;

  swap_core #(.WIDTH(WIDTH)) u_core (
    .in   (in),
    .mode (mode),
    .out  (perm_p0)
  );

  // Stage p0 -> p1: capture the permutation when valid, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        data_p1 <= perm_p0;
      end
    end
  end

  assign out       = data_p1;
  assign out_valid = vld_p1;

endmodule : swap

// File: tb/tb_swap.sv
// Testbench for swap: scoreboard of expected {valid, data} per cycle.
module tb_swap;

  localparam int W = 8;

  typedef struct {
    logic         vld;
    logic [W-1:0] data;
    string        tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic [1:0]   mode;
  logic         in_valid;
  logic [W-1:0] dout;
  logic         out_valid;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t         sb[$];
  logic [W-1:0] mdl_data;
  logic         mdl_vld;

  swap #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (din),
    .mode      (mode),
    .in_valid  (in_valid),
    .out       (dout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference: shifts, streaming and masks instead of index wiring
  function automatic logic [W-1:0] ref_perm(input logic [W-1:0] x, input logic [1:0] m);
    logic [W-1:0] r;
    case (m)
      2'b00:   r = (x << (W/2)) | (x >> (W/2));
      2'b01:   r = {<<{x}};
      2'b10:   r = x;
      default: r = ((x & 8'h55) << 1) | ((x & 8'hAA) >> 1);
    endcase
    return r;
  endfunction

  // Drive one cycle, push the expectation, then pop and compare after the edge
  task automatic cycle(input string tag, input logic r, input logic v,
                       input logic [1:0] m, input logic [W-1:0] d);
    exp_t e;
    rst = r; in_valid = v; mode = m; din = d;
    if (r) begin
      mdl_data = '0;
      mdl_vld  = 1'b0;
    end else if (v) begin
      mdl_data = ref_perm(d, m);
      mdl_vld  = 1'b1;
    end else begin
      mdl_vld  = 1'b0;
    end
    e.vld = mdl_vld; e.data = mdl_data; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_vld"}, {31'd0, out_valid}, {31'd0, e.vld});
      chk({e.tag, "_out"}, {24'd0, dout}, {24'd0, e.data});
    end
  endtask

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [1:0]   m;

    rst = 1'b1; in_valid = 1'b0; mode = 2'b00; din = '0;
    mdl_data = '0; mdl_vld = 1'b0;
    @(negedge clk);

    // Reset state
    cycle("rst0", 1'b1, 1'b0, 2'b00, 8'h00);
    cycle("rst1", 1'b1, 1'b1, 2'b10, 8'hA5);

    // Nibble swap, first capture after reset
    cycle("nib_c7", 1'b0, 1'b1, 2'b00, 8'b11000111);
    chk("nib_c7_lit", {24'd0, dout}, 32'h7C);
    cycle("nib_f0", 1'b0, 1'b1, 2'b00, 8'b11110000);
    chk("nib_f0_lit", {24'd0, dout}, 32'h0F);
    // Hold with in_valid low, even with changing in/mode
    cycle("hold0", 1'b0, 1'b0, 2'b01, 8'h5A);
    chk("hold0_lit", {24'd0, dout}, 32'h0F);
    cycle("hold1", 1'b0, 1'b0, 2'b11, 8'hFF);

    // Back-to-back modes on the same operand
    cycle("bitrev", 1'b0, 1'b1, 2'b01, 8'b10110001);
    chk("bitrev_lit", {24'd0, dout}, 32'h8D);
    cycle("pass", 1'b0, 1'b1, 2'b10, 8'b10110001);
    chk("pass_lit", {24'd0, dout}, 32'hB1);
    cycle("pair", 1'b0, 1'b1, 2'b11, 8'b10110001);
    chk("pair_lit", {24'd0, dout}, 32'h72);

    // Reset wins over a simultaneous valid input
    cycle("rst_pri", 1'b1, 1'b1, 2'b10, 8'hFF);
    chk("rst_pri_lit", {24'd0, dout}, 32'h00);
    cycle("post_rst", 1'b0, 1'b1, 2'b00, 8'h3C);
    chk("post_rst_lit", {24'd0, dout}, 32'hC3);

    // Random sweep; each output is fed back through the same mode
    for (int i = 0; i < 1000; i++) begin
      x = W'($urandom);
      m = 2'($urandom_range(0, 3));
      cycle("rnd", 1'b0, 1'b1, m, x);
      y = dout;
      cycle("rnd_inv", 1'b0, 1'b1, m, y);
      chk("rnd_involution", {24'd0, dout}, {24'd0, x});
      if (($urandom & 7) == 0) begin
        cycle("rnd_idle", 1'b0, 1'b0, 2'($urandom), W'($urandom));
      end
    end

    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_swap
